// File: rtl/sram_gen_pkg.sv
// Shared types and constants for the 1RW+1R SRAM wrapper family.
// Holds the sequencing FSM encoding, collision counter width and read latency limits.
package sram_gen_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int COLL_CNT_W   = 16;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_1rw1r_gen_if.sv
// Bus bundle for sram_1rw1r_gen: port 0 read/write, port 1 read-only, init and collision status.
// The master modport drives requests; the slave modport is the memory side.
interface sram_1rw1r_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    import sram_gen_pkg::*;

    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dvld0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dvld1;
    logic                  init_busy;
    logic                  coll_clr;
    logic [COLL_CNT_W-1:0] coll_cnt;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1, coll_clr,
        input  dout0, dvld0, dout1, dvld1, init_busy, coll_cnt
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1, coll_clr,
        output dout0, dvld0, dout1, dvld1, init_busy, coll_cnt
    );

endinterface

// File: rtl/sram_gen_rdpipe.sv
// Read-data pipeline of configurable depth; each stage only loads when valid data arrives,
// so the output word holds its last value between reads.
module sram_gen_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LAT        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LAT-1:0]                 vld_q;
    logic [LAT-1:0]                 vld_d;
    logic [LAT-1:0][DATA_WIDTH-1:0] data_q;
    logic [LAT-1:0][DATA_WIDTH-1:0] data_d;

    always_comb begin
        vld_d     = '0;
        data_d    = data_q;
        vld_d[0]  = in_vld;
        data_d[0] = in_vld ? in_data : data_q[0];
        for (int i = 1; i < LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    // Reset flushes any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q[LAT-1];
    assign out_data = data_q[LAT-1];

endmodule

// File: rtl/sram_1rw1r_gen.sv
// Behavioural 1RW+1R SRAM with byte masks, post-reset zero fill and write-first collision merge.
// Same-address port 0 write / port 1 read pairs are counted in a saturating counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | sweeping init_cnt over the array writing zeros, requests ignored
//   READY | normal operation, both ports accept requests
module sram_1rw1r_gen
    import sram_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int READ_LAT   = 1,
    parameter int INIT_ZERO  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_1rw1r_gen_if.slave        bus
);

    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int LAT        = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;
    localparam sram_state_e RST_STATE = (INIT_ZERO != 0) ? INIT : READY;
    localparam logic        RST_BUSY  = (INIT_ZERO != 0);

    sram_state_e           state_q, state_d;
    logic                  init_busy_q, init_busy_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [COLL_CNT_W-1:0] coll_cnt_q, coll_cnt_d;

    logic                  acc0, acc1, wr0, rd0, coll;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_WMASKS-1:0] mem_wbe;
    logic [DATA_WIDTH-1:0] rd0_data, rd1_data;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = READY;
        endcase
        init_busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            init_busy_q <= RST_BUSY;
            init_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_busy_q <= init_busy_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    // An all-zero mask is a no-op write: no array update, no collision.
    always_comb begin
        acc0 = !bus.csb0 && !init_busy_q;
        acc1 = !bus.csb1 && !init_busy_q;
        wr0  = acc0 && !bus.web0 && (bus.wmask0 != '0);
        rd0  = acc0 && bus.web0;
        coll = wr0 && acc1 && (bus.addr0 == bus.addr1);
    end

    always_comb begin
        if (init_busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else begin
            mem_we    = wr0;
            mem_waddr = bus.addr0;
            mem_wdata = bus.din0;
            mem_wbe   = bus.wmask0;
        end
    end

    // Storage is never reset; only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NUM_WMASKS; b++) begin
                if (mem_wbe[b]) begin
                    mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd0_data = mem_q[bus.addr0];
        rd1_data = mem_q[bus.addr1];
        for (int b = 0; b < NUM_WMASKS; b++) begin
            if (coll && bus.wmask0[b]) begin
                rd1_data[b*8 +: 8] = bus.din0[b*8 +: 8];
            end
        end
    end

    always_comb begin
        if (bus.coll_clr) begin
            coll_cnt_d = '0;
        end else if (coll) begin
            coll_cnt_d = sat_inc(coll_cnt_q);
        end else begin
            coll_cnt_d = coll_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt_q <= '0;
        end else begin
            coll_cnt_q <= coll_cnt_d;
        end
    end

    sram_gen_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LAT        (LAT)
    ) u_rdpipe0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd0),
        .in_data  (rd0_data),
        .out_vld  (bus.dvld0),
        .out_data (bus.dout0)
    );

    sram_gen_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LAT        (LAT)
    ) u_rdpipe1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (acc1),
        .in_data  (rd1_data),
        .out_vld  (bus.dvld1),
        .out_data (bus.dout1)
    );

    assign bus.init_busy = init_busy_q;
    assign bus.coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_sram_1rw1r_gen.sv
// Scoreboard bench for sram_1rw1r_gen: one instance at READ_LAT=1 and one at READ_LAT=2,
// both driven by the same directed stimulus with hand-computed read data.
module tb_sram_1rw1r_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_1rw1r_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();
    sram_1rw1r_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b2 ();

    assign b2.csb0     = b1.csb0;
    assign b2.web0     = b1.web0;
    assign b2.wmask0   = b1.wmask0;
    assign b2.addr0    = b1.addr0;
    assign b2.din0     = b1.din0;
    assign b2.csb1     = b1.csb1;
    assign b2.addr1    = b1.addr1;
    assign b2.coll_clr = b1.coll_clr;

    sram_1rw1r_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LAT(1), .INIT_ZERO(1)) dut_lat1 (
        .clk (clk), .rst_n (rst_n), .bus (b1.slave)
    );
    sram_1rw1r_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LAT(2), .INIT_ZERO(1)) dut_lat2 (
        .clk (clk), .rst_n (rst_n), .bus (b2.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream index: 0 = lat1 port0, 1 = lat1 port1, 2 = lat2 port0, 3 = lat2 port1.
    logic [31:0] exp_q [4][$];
    int          exp_c [4][$];
    logic [31:0] last [4] = '{default: '0};
    logic [15:0] exp_coll = '0;
    logic [3:0]  mon_vld;
    logic [31:0] mon_dout [4];
    logic [31:0] mon_e;
    int          mon_c;

    always_comb begin
        mon_vld     = {b2.dvld1, b2.dvld0, b1.dvld1, b1.dvld0};
        mon_dout[0] = b1.dout0;
        mon_dout[1] = b1.dout1;
        mon_dout[2] = b2.dout0;
        mon_dout[3] = b2.dout1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (!rst_n) begin
                last[p] = '0;
            end else if (mon_vld[p]) begin
                if (exp_q[p].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_dvld stream %0d: got dvld=1 data %08h expected no read", p, mon_dout[p]);
                    last[p] = mon_dout[p];
                end else begin
                    mon_e = exp_q[p].pop_front();
                    mon_c = exp_c[p].pop_front();
                    chk($sformatf("rd_data_s%0d", p), mon_dout[p], mon_e);
                    chk($sformatf("rd_cycle_s%0d", p), 32'(cyc), 32'(mon_c));
                    last[p] = mon_e;
                end
            end else begin
                chk($sformatf("hold_s%0d", p), mon_dout[p], last[p]);
            end
        end
    end

    task automatic issue(input logic c0, input logic w0, input logic [3:0] m0, input logic [3:0] a0,
                         input logic [31:0] d0, input logic c1, input logic [3:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1, input logic clr);
        b1.csb0 = c0; b1.web0 = w0; b1.wmask0 = m0; b1.addr0 = a0; b1.din0 = d0;
        b1.csb1 = c1; b1.addr1 = a1; b1.coll_clr = clr;
        @(posedge clk); #1;
        if (!c0 && w0) begin
            exp_q[0].push_back(e0); exp_c[0].push_back(cyc);
            exp_q[2].push_back(e0); exp_c[2].push_back(cyc + 1);
        end
        if (!c1) begin
            exp_q[1].push_back(e1); exp_c[1].push_back(cyc);
            exp_q[3].push_back(e1); exp_c[3].push_back(cyc + 1);
        end
        if (clr) exp_coll = '0;
        else if (!c0 && !w0 && m0 != 4'h0 && !c1 && a0 == a1 && exp_coll != 16'hFFFF) exp_coll++;
        chk("coll_cnt_lat1", {16'h0, b1.coll_cnt}, {16'h0, exp_coll});
        chk("coll_cnt_lat2", {16'h0, b2.coll_cnt}, {16'h0, exp_coll});
    endtask

    task automatic set_idle();
        b1.csb0 = 1'b1; b1.web0 = 1'b1; b1.wmask0 = 4'h0; b1.addr0 = '0; b1.din0 = '0;
        b1.csb1 = 1'b1; b1.addr1 = '0; b1.coll_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_rst();
        chk("rst_dout0_lat1", b1.dout0, 32'h0);
        chk("rst_dout1_lat1", b1.dout1, 32'h0);
        chk("rst_dout0_lat2", b2.dout0, 32'h0);
        chk("rst_dout1_lat2", b2.dout1, 32'h0);
        chk("rst_dvld", {28'h0, b2.dvld1, b2.dvld0, b1.dvld1, b1.dvld0}, 32'h0);
        chk("rst_coll_cnt", {b2.coll_cnt, b1.coll_cnt}, 32'h0);
        chk("rst_init_busy", {30'h0, b2.init_busy, b1.init_busy}, 32'h3);
    endtask

    task automatic wait_init();
        int n = 0;
        while ((b1.init_busy || b2.init_busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_busy_cycles", 32'(n), 32'd16);
        chk("init_busy_both_low", {30'h0, b2.init_busy, b1.init_busy}, 32'h0);
    endtask

    initial begin
        set_idle();
        repeat (3) @(posedge clk);
        #1 check_rst();
        @(negedge clk); #1 rst_n = 1'b1;

        // Port 0 read during INIT must be ignored; reset again once 9 addresses are cleared.
        b1.csb0 = 1'b0; b1.web0 = 1'b1; b1.addr0 = 4'd2;
        repeat (9) @(posedge clk);
        #1 chk("busy_mid_init", {31'h0, b1.init_busy}, 32'h1);
        rst_n = 1'b0;
        #1 check_rst();
        @(negedge clk); #1 rst_n = 1'b1;

        // Write and port 1 read during INIT: no dvld, no array change.
        b1.csb0 = 1'b0; b1.web0 = 1'b0; b1.wmask0 = 4'hF; b1.addr0 = 4'd2; b1.din0 = 32'hDEADBEEF;
        b1.csb1 = 1'b0; b1.addr1 = 4'd2;
        wait_init();

        issue(0, 1, 4'h0, 4'd2, 32'h0,          0, 4'd2, 32'h0,        32'h0,        0);
        issue(0, 1, 4'h0, 4'd5, 32'h0,          1, 4'd0, 32'h0,        32'h0,        0);
        issue(0, 0, 4'hF, 4'd3, 32'hAABBCCDD,   1, 4'd0, 32'h0,        32'h0,        0);
        issue(0, 0, 4'h5, 4'd3, 32'h11223344,   1, 4'd0, 32'h0,        32'h0,        0);
        issue(0, 1, 4'h0, 4'd3, 32'h0,          0, 4'd3, 32'hAA22CC44, 32'hAA22CC44, 0);
        // Zero-mask write alongside a same-address read: no merge, no collision.
        issue(0, 0, 4'h0, 4'd3, 32'h0,          0, 4'd3, 32'h0,        32'hAA22CC44, 0);
        issue(0, 0, 4'h3, 4'd7, 32'hFFFFFFFF,   0, 4'd7, 32'h0,        32'h0000FFFF, 0);
        // Back-to-back reads on both ports.
        issue(0, 1, 4'h0, 4'd3, 32'h0,          0, 4'd7, 32'hAA22CC44, 32'h0000FFFF, 0);
        issue(0, 1, 4'h0, 4'd7, 32'h0,          0, 4'd3, 32'h0000FFFF, 32'hAA22CC44, 0);
        issue(0, 1, 4'h0, 4'd5, 32'h0,          0, 4'd5, 32'h0,        32'h0,        0);
        issue(0, 1, 4'h0, 4'd3, 32'h0,          1, 4'd0, 32'hAA22CC44, 32'h0,        0);
        idle(5);

        issue(1, 1, 4'h0, 4'd0, 32'h0,          1, 4'd0, 32'h0,        32'h0,        1);
        for (int i = 0; i < 16'hFFFE; i++) begin
            issue(0, 0, 4'hF, 4'd8, 32'(i),     0, 4'd8, 32'h0,        32'(i),       0);
        end
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 4'hF, 4'd9, 32'h0BAD0000 + 32'(i), 0, 4'd9, 32'h0, 32'h0BAD0000 + 32'(i), 0);
        end
        chk("coll_sat", {16'h0, b1.coll_cnt}, 32'h0000FFFF);
        issue(0, 0, 4'hF, 4'd8, 32'h00005A5A,   0, 4'd8, 32'h0,        32'h00005A5A, 1);
        chk("coll_clr_wins", {16'h0, b2.coll_cnt}, 32'h0);
        issue(0, 0, 4'hC, 4'd8, 32'h12340000,   0, 4'd8, 32'h0,        32'h12345A5A, 0);
        idle(3);

        // Reset with a read in flight: it must never produce a dvld.
        issue(0, 1, 4'h0, 4'd3, 32'h0,          1, 4'd0, 32'hAA22CC44, 32'h0,        0);
        rst_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            exp_q[p].delete();
            exp_c[p].delete();
        end
        exp_coll = '0;
        #1 check_rst();
        set_idle();
        @(negedge clk); #1 rst_n = 1'b1;
        wait_init();
        issue(0, 1, 4'h0, 4'd3, 32'h0,          0, 4'd8, 32'h0,        32'h0,        0);
        idle(6);

        for (int p = 0; p < 4; p++) begin
            chk($sformatf("queue_drained_s%0d", p), 32'(exp_q[p].size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
